alu_issue_wb: RTL and testbench
===============================

// Module: alu_issue_wb
// PURPOSE
//  Issue/writeback stage wrapped around the 8-bit alu.
//  - Accepts one instruction over a valid/ready handshake.
//  - Reads operands from an internal register file and drives registered operands and op_code to the alu.
//  - Captures the alu result and flags, writes the result back, and presents it downstream over valid/ready.
//  - Sits between the instruction fetch/decode stage and the alu.
// PARAMETERS
//  DATA_W   8   operand width; must match alu a/b width (alu result is DATA_W+1)
//  NREG     4   register count, power of 2; REG_AW = $clog2(NREG)
//  INSTR_W  3+1+2*REG_AW+DATA_W (16 at defaults); derived, not overridable
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        synchronous, active-high reset
//  instr        in   INSTR_W  [15:13] op, [12] use_imm, [11:10] rd, [9:8] rs, [7:0] imm
//  instr_valid  in   1        instr is valid
//  instr_ready  out  1        stage can accept (high only in IDLE)
//  alu_a        out  DATA_W   registered operand A = R[rd]
//  alu_b        out  DATA_W   registered operand B = use_imm ? imm : R[rs]
//  alu_op_code  out  3        registered op to alu
//  alu_result   in   DATA_W+1 combinational alu result
//  alu_gt/lt/eq in   1 each   combinational alu compare flags
//  res_valid    out  1        res_data/flags valid (RESP state)
//  res_ready    in   1        downstream accepts result
//  res_data     out  DATA_W   value written to rd (or imm for LOAD)
//  flag_c/gt/lt/eq out 1 each architectural flags (registered)
//  dbg_addr     in   REG_AW   debug read address
//  dbg_data     out  DATA_W   combinational R[dbg_addr]
// BEHAVIOUR
//  - Reset: state IDLE; all R[i] = 0; alu_a = alu_b = 0; alu_op_code = 0.
//    res_data = 0; all flags = 0; res_valid = 0; instr_ready = 1 the cycle after rst deasserts.
//  - FSM:
//    - IDLE: instr_ready = 1. On instr_valid, latch rd/op/imm, load alu_a/alu_b/alu_op_code -> EXEC.
//    - EXEC: alu settles combinationally; at the clock edge commit writeback and flags -> RESP.
//    - RESP: res_valid = 1; hold res_data/flags stable until res_ready; transfer -> IDLE.
//  - Latency: accept at edge N, R[rd] updated at N+1, res_valid high from N+1. Throughput is 1 instruction per 3 cycles with res_ready tied high.
//  - Ops 000-101 (ALU ops):
//    - R[rd] <= alu_result[DATA_W-1:0].
//    - flag_c <= alu_result[DATA_W] for 000/001; flag_c <= 0 for 010-101.
//    - gt/lt/eq <= alu flags.
//    - 001 borrow: flag_c = 1 when a < b (9-bit wrap, e.g. 0x00-0x01 = 0x1FF).
//    - 101 writes 0 or 1 into rd.
//    - 100 ignores alu_b.
//  - Op 110 LOAD: R[rd] <= imm; res_data = imm; flags unchanged.
//  - Op 111 CMP: no register write; gt/lt/eq updated; flag_c unchanged; res_data = R[rd].
//  - No hazards: writeback completes before the next operand read, so back-to-back dependent instructions see new values.
//  - rd == rs: both operands read the same pre-write value.
//  - instr_valid while not IDLE: ignored; instr_ready = 0. Upstream must hold instr.
//  - Reset mid-operation (EXEC or RESP): instruction abandoned, no writeback, all state returns to reset values.
//  - dbg_data reflects a write from the cycle after the write edge.
// STRUCTURE
//  - Shared package cpu_pkg: opcode localparams (OP_ADD=000 ... OP_GT=101, OP_LOAD=110, OP_CMP=111), instruction field offsets, FSM state encoding (IDLE/EXEC/RESP, 2 bits).
//  - One sub-module reg_file: NREG x DATA_W, two async read ports plus a debug read port, one sync write port, synchronous reset to zero.
//  - FSM, operand registers and flag registers live in alu_issue_wb. The alu is instantiated by the parent, not inside this block.
// TESTING
//  - Reset then LOAD r0=0xF0, LOAD r1=0x20, ADD r0,r1 -> R0=0x10, flag_c=1, res_data=0x10, res_valid 1 cycle after accept.
//  - SUB r2(0x00) - imm 0x01 -> R2=0xFF, flag_c=1, lt=1.
//  - SUB 0x05 - 0x05 -> R=0x00, flag_c=0, eq=1.
//  - CMP r0(0x10) vs r1(0x20) -> lt=1, gt=0, R0 unchanged, flag_c unchanged.
//  - res_ready low 5 cycles in RESP -> res_valid/res_data stable, instr_ready=0, a second instr_valid is not accepted.
//  - Dependent chain: LOAD r3=0x03, SHL r3 x3 -> R3=0x18.
//  - Reset during EXEC of ADD r0 -> R0=0, res_valid never asserted.
//  - Random ops against a reference model; check R[] via dbg_addr.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the issue/writeback stage: opcodes, default
// instruction layout and FSM state encoding.
package cpu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_AND  = 3'b010;
  localparam logic [OP_W-1:0] OP_OR   = 3'b011;
  localparam logic [OP_W-1:0] OP_SHL  = 3'b100;
  localparam logic [OP_W-1:0] OP_GT   = 3'b101;
  localparam logic [OP_W-1:0] OP_LOAD = 3'b110;
  localparam logic [OP_W-1:0] OP_CMP  = 3'b111;

  // Field offsets of the 16-bit instruction at default parameters
  localparam int INSTR_OP_LSB  = 13;
  localparam int INSTR_IMM_BIT = 12;
  localparam int INSTR_RD_LSB  = 10;
  localparam int INSTR_RS_LSB  = 8;
  localparam int INSTR_IMM_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/reg_file.sv
// NREG x DATA_W register file: two async operand read ports, an async
// debug read port and one synchronous write port, cleared by reset.
module reg_file #(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  localparam int REG_AW = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [DATA_W-1:0] rb_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ra_data  = mem[ra_addr];
  assign rb_data  = mem[rb_addr];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around an external combinational alu: reads operands,
// registers them to the alu, writes the result back and hands it downstream.
module alu_issue_wb
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREG   = 4,
  localparam int REG_AW  = $clog2(NREG),
  localparam int INSTR_W = 3 + 1 + 2 * REG_AW + DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INSTR_W-1:0] instr,
  input  logic               instr_valid,
  output logic               instr_ready,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [2:0]         alu_op_code,
  input  logic [DATA_W:0]    alu_result,
  input  logic               alu_gt,
  input  logic               alu_lt,
  input  logic               alu_eq,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [DATA_W-1:0]  res_data,
  output logic               flag_c,
  output logic               flag_gt,
  output logic               flag_lt,
  output logic               flag_eq,
  input  logic [REG_AW-1:0]  dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
);

  state_e state_q, state_d;

  logic [REG_AW-1:0] rd_q;
  logic [2:0]        op_q;
  logic [DATA_W-1:0] imm_q;

  logic [2:0]        instr_op;
  logic              instr_use_imm;
  logic [REG_AW-1:0] instr_rd, instr_rs;
  logic [DATA_W-1:0] instr_imm;
  logic [DATA_W-1:0] rf_rd_data, rf_rs_data;
  logic              accept, wb_we;
  logic [DATA_W-1:0] wb_data;

  assign instr_op      = instr[INSTR_W-1 -: 3];
  assign instr_use_imm = instr[INSTR_W-4];
  assign instr_rd      = instr[DATA_W+2*REG_AW-1 -: REG_AW];
  assign instr_rs      = instr[DATA_W+REG_AW-1 -: REG_AW];
  assign instr_imm     = instr[DATA_W-1:0];

  reg_file #(.DATA_W(DATA_W), .NREG(NREG)) u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .ra_addr  (instr_rd),
    .ra_data  (rf_rd_data),
    .rb_addr  (instr_rs),
    .rb_data  (rf_rs_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (wb_we),
    .waddr    (rd_q),
    .wdata    (wb_data)
  );

  assign accept  = (state_q == IDLE) && instr_valid;
  assign wb_we   = (state_q == EXEC) && (op_q != OP_CMP);
  assign wb_data = (op_q == OP_LOAD) ? imm_q : alu_result[DATA_W-1:0];

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    res_valid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = EXEC;
      end
      EXEC: state_d = RESP;
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rd_q        <= '0;
      op_q        <= '0;
      imm_q       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op_code <= '0;
      res_data    <= '0;
      flag_c      <= 1'b0;
      flag_gt     <= 1'b0;
      flag_lt     <= 1'b0;
      flag_eq     <= 1'b0;
    end else begin
      state_q <= state_d;
      // issue: operands are read before any later writeback can land
      if (accept) begin
        rd_q        <= instr_rd;
        op_q        <= instr_op;
        imm_q       <= instr_imm;
        alu_a       <= rf_rd_data;
        alu_b       <= instr_use_imm ? instr_imm : rf_rs_data;
        alu_op_code <= instr_op;
      end
      // writeback: alu has settled on the registered operands
      if (state_q == EXEC) begin
        res_data <= (op_q == OP_CMP) ? alu_a : wb_data;
        if (op_q != OP_LOAD) begin
          flag_gt <= alu_gt;
          flag_lt <= alu_lt;
          flag_eq <= alu_eq;
        end
        if (op_q == OP_ADD || op_q == OP_SUB) flag_c <= alu_result[DATA_W];
        else if (op_q != OP_LOAD && op_q != OP_CMP) flag_c <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Directed and random bench for alu_issue_wb with a behavioural alu and a
// scoreboard of expected results checked at each downstream transfer.
module tb_alu_issue_wb;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        instr_valid, instr_ready;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op_code;
  logic [8:0]  alu_result;
  logic        alu_gt, alu_lt, alu_eq;
  logic        res_valid, res_ready;
  logic [7:0]  res_data;
  logic        flag_c, flag_gt, flag_lt, flag_eq;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  typedef struct packed {
    logic [7:0] data;
    logic       c, gt, lt, eq;
    logic [1:0] rd;
    logic [7:0] rval;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_reg [4];
  logic       m_c, m_gt, m_lt, m_eq;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_wb #(.DATA_W(8), .NREG(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .alu_a(alu_a), .alu_b(alu_b),
    .alu_op_code(alu_op_code), .alu_result(alu_result), .alu_gt(alu_gt),
    .alu_lt(alu_lt), .alu_eq(alu_eq), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .flag_c(flag_c),
    .flag_gt(flag_gt), .flag_lt(flag_lt), .flag_eq(flag_eq),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  function automatic logic [8:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {a, 1'b0};
      3'd5:    return {8'd0, a > b};
      default: return 9'd0;
    endcase
  endfunction

  always_comb begin
    alu_result = alu_f(alu_op_code, alu_a, alu_b);
    alu_gt     = alu_a > alu_b;
    alu_lt     = alu_a < alu_b;
    alu_eq     = alu_a == alu_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_reg[i] = 8'h00;
    {m_c, m_gt, m_lt, m_eq} = 4'b0000;
    sb.delete();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk(tag, dbg_data, m_reg[i]);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic ui, input logic [1:0] rd,
                       input logic [1:0] rs, input logic [7:0] imm, input int stall);
    logic [7:0] a, b;
    logic [8:0] r;
    exp_t       e;
    int         n;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_issue", instr_ready, 1);
    instr       = {op, ui, rd, rs, imm};
    instr_valid = 1'b1;
    dbg_addr    = rd;
    if (stall > 0) res_ready = 1'b0;
    a = m_reg[rd];
    b = ui ? imm : m_reg[rs];
    @(posedge clk);
    r = alu_f(op, a, b);
    if (op == OP_LOAD) begin
      m_reg[rd] = imm;
      e.data = imm;
    end else if (op == OP_CMP) begin
      {m_gt, m_lt, m_eq} = {a > b, a < b, a == b};
      e.data = a;
    end else begin
      m_reg[rd] = r[7:0];
      m_c = (op == OP_ADD || op == OP_SUB) ? r[8] : 1'b0;
      {m_gt, m_lt, m_eq} = {a > b, a < b, a == b};
      e.data = r[7:0];
    end
    e.c = m_c; e.gt = m_gt; e.lt = m_lt; e.eq = m_eq;
    e.rd = rd; e.rval = m_reg[rd];
    sb.push_back(e);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("exec_res_valid", res_valid, 0);
    chk("exec_instr_ready", instr_ready, 0);
    chk("exec_alu_a", alu_a, a);
    chk("exec_alu_b", alu_b, b);
    chk("exec_alu_op", alu_op_code, op);
    @(negedge clk);
    chk("resp_res_valid", res_valid, 1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("res_data", res_data, e.data);
      chk("flag_c", flag_c, e.c);
      chk("flag_gt", flag_gt, e.gt);
      chk("flag_lt", flag_lt, e.lt);
      chk("flag_eq", flag_eq, e.eq);
      chk("wb_reg", dbg_data, e.rval);
    end
    for (int k = 0; k < stall; k++) begin
      instr       = {OP_LOAD, 1'b1, 2'd3, 2'd0, 8'hAA};
      instr_valid = 1'b1;
      @(negedge clk);
      chk("stall_res_valid", res_valid, 1);
      chk("stall_res_data", res_data, e.data);
      chk("stall_flag_c", flag_c, e.c);
      chk("stall_instr_ready", instr_ready, 0);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    chk("idle_instr_ready", instr_ready, 1);
    chk("idle_res_valid", res_valid, 0);
    if (stall > 0) begin
      dbg_addr = 2'd3;
      #1 chk("stall_no_accept", dbg_data, m_reg[3]);
    end
  endtask

  initial begin
    rst = 1'b1; instr = '0; instr_valid = 1'b0; res_ready = 1'b1; dbg_addr = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_instr_ready", instr_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_flags", {flag_c, flag_gt, flag_lt, flag_eq}, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op_code, 0);
    check_regs("rst_reg");
    @(negedge clk);

    issue(OP_LOAD, 1'b1, 2'd0, 2'd0, 8'hF0, 0);
    issue(OP_LOAD, 1'b1, 2'd1, 2'd0, 8'h20, 0);
    issue(OP_ADD,  1'b0, 2'd0, 2'd1, 8'h00, 0);
    dbg_addr = 2'd0;
    #1 chk("add_r0_const", dbg_data, 8'h10);
    chk("add_carry_const", flag_c, 1);

    issue(OP_LOAD, 1'b1, 2'd2, 2'd0, 8'h05, 0);
    issue(OP_SUB,  1'b1, 2'd2, 2'd0, 8'h05, 0);
    chk("sub_eq_const", {flag_c, flag_eq}, 2'b01);
    issue(OP_SUB,  1'b1, 2'd2, 2'd0, 8'h01, 0);
    dbg_addr = 2'd2;
    #1 chk("sub_borrow_r2_const", dbg_data, 8'hFF);
    chk("sub_borrow_flags_const", {flag_c, flag_lt}, 2'b11);

    issue(OP_CMP, 1'b0, 2'd0, 2'd1, 8'h00, 0);
    chk("cmp_flags_const", {flag_c, flag_gt, flag_lt, flag_eq}, 4'b1010);
    dbg_addr = 2'd0;
    #1 chk("cmp_r0_const", dbg_data, 8'h10);

    issue(OP_OR, 1'b1, 2'd1, 2'd1, 8'h0F, 5);

    issue(OP_LOAD, 1'b1, 2'd3, 2'd0, 8'h03, 0);
    issue(OP_SHL,  1'b0, 2'd3, 2'd0, 8'h00, 0);
    issue(OP_SHL,  1'b0, 2'd3, 2'd0, 8'h00, 0);
    issue(OP_SHL,  1'b0, 2'd3, 2'd0, 8'h00, 0);
    dbg_addr = 2'd3;
    #1 chk("shl_chain_const", dbg_data, 8'h18);
    issue(OP_ADD, 1'b0, 2'd3, 2'd3, 8'h00, 0);
    issue(OP_GT,  1'b0, 2'd2, 2'd3, 8'h00, 0);

    // reset while an ADD into r0 is in EXEC
    @(negedge clk);
    instr = {OP_ADD, 1'b0, 2'd0, 2'd1, 8'h00};
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_res_valid", res_valid, 0);
    end
    chk("abort_flags", {flag_c, flag_gt, flag_lt, flag_eq}, 0);
    check_regs("abort_reg");
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      issue(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), (i % 7 == 3) ? 2 : 0);
    end
    check_regs("rand_reg");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
